// File: rtl/mem_read_arbiter.sv
// Two-client round-robin read arbiter in front of main memory: one outstanding
// miss, one-cycle line-fill strobe, WAIT timeout abort. State updates on negedge clk.
module mem_read_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_arvalid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_rvalid_mm,
  output logic [DATA_W-1:0] req0_data_mm,
  input  logic              req1_arvalid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_rvalid_mm,
  output logic [DATA_W-1:0] req1_data_mm,
  output logic              mem_arvalid,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_data,
  output logic [1:0]        grant,
  output logic              err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] TO_LIMIT = TIMEOUT[7:0];

  state_t              state_q, state_d;
  logic                arv_q, arv_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [1:0]          grant_q, grant_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [1:0]          mask_q, mask_d;
  logic                last_q, last_d;   // 1: requester 1 was served last
  logic [DATA_W-1:0]   data_q, data_d;

  logic elig0, elig1, pick1;

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      arv_q   <= 1'b0;
      addr_q  <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      mask_q  <= '0;
      last_q  <= 1'b1;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      arv_q   <= arv_d;
      addr_q  <= addr_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    arv_d   = arv_q;
    addr_d  = addr_q;
    grant_d = grant_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;
    data_d  = data_q;
    // A dropped arvalid always clears its mask, even on the cycle a fill completes.
    mask_d  = mask_q & {req1_arvalid, req0_arvalid};
    elig0   = req0_arvalid & ~mask_q[0];
    elig1   = req1_arvalid & ~mask_q[1];
    pick1   = elig1 & (~elig0 | ~last_q);
    case (state_q)
      S_IDLE: begin
        if (elig0 | elig1) begin
          grant_d = pick1 ? 2'b10 : 2'b01;
          addr_d  = pick1 ? req1_addr : req0_addr;
          arv_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          data_d  = mem_data;
          arv_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == TO_LIMIT) begin
          arv_d   = 1'b0;
          err_d   = 1'b1;
          grant_d = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        last_d  = grant_q[1];
        mask_d  = (mask_q | grant_q) & {req1_arvalid, req0_arvalid};
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign req0_rvalid_mm = (state_q == S_RESP) & grant_q[0];
  assign req1_rvalid_mm = (state_q == S_RESP) & grant_q[1];
  assign req0_data_mm   = req0_rvalid_mm ? data_q : '0;
  assign req1_data_mm   = req1_rvalid_mm ? data_q : '0;
  assign mem_arvalid    = arv_q;
  assign mem_addr       = addr_q;
  assign grant          = grant_q;
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed bench for mem_read_arbiter: DUT updates on negedge, bench samples
// outputs and drives inputs just after each posedge.
module tb_mem_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_arvalid, req1_arvalid;
  logic [31:0] req0_addr, req1_addr;
  logic        req0_rvalid_mm, req1_rvalid_mm;
  logic [63:0] req0_data_mm, req1_data_mm;
  logic        mem_arvalid;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [63:0] mem_data;
  logic [1:0]  grant;
  logic        err_timeout;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  mem_read_arbiter #(.ADDR_W(32), .DATA_W(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_arvalid(req0_arvalid), .req0_addr(req0_addr),
    .req0_rvalid_mm(req0_rvalid_mm), .req0_data_mm(req0_data_mm),
    .req1_arvalid(req1_arvalid), .req1_addr(req1_addr),
    .req1_rvalid_mm(req1_rvalid_mm), .req1_data_mm(req1_data_mm),
    .mem_arvalid(mem_arvalid), .mem_addr(mem_addr),
    .mem_rvalid(mem_rvalid), .mem_data(mem_data),
    .grant(grant), .err_timeout(err_timeout)
  );

  task automatic step();
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0_arvalid = 1'b1; req1_arvalid = 1'b1;
    req0_addr = 32'hAAAA_0000; req1_addr = 32'hBBBB_0000;
    mem_rvalid = 1'b1; mem_data = 64'h1111_2222_3333_4444;
    step(); step();
    checks++; if (mem_arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b exp 0", mem_arvalid); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", mem_addr); end
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b exp 00", grant); end
    checks++; if ({req0_rvalid_mm, req1_rvalid_mm, err_timeout} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b exp 000", {req0_rvalid_mm, req1_rvalid_mm, err_timeout}); end
    checks++; if ({req0_data_mm, req1_data_mm} !== 128'h0) begin errors++; $display("FAIL reset_data: got %h %h exp 0", req0_data_mm, req1_data_mm); end
    req0_arvalid = 1'b0; req1_arvalid = 1'b0; mem_rvalid = 1'b0; rst_n = 1'b1;
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_release_grant: got %b exp 00", grant); end
  endtask

  task automatic test_single();
    req0_arvalid = 1'b1; req0_addr = 32'h0000_1040;
    step();
    checks++; if (mem_arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid: got %b exp 1", mem_arvalid); end
    checks++; if (mem_addr !== 32'h0000_1040) begin errors++; $display("FAIL single_addr: got %h exp 00001040", mem_addr); end
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b exp 01", grant); end
    step();
    checks++; if ({mem_arvalid, req0_rvalid_mm} !== 2'b10) begin errors++; $display("FAIL single_wait: got %b exp 10", {mem_arvalid, req0_rvalid_mm}); end
    step();
    mem_rvalid = 1'b1; mem_data = 64'hDEAD_BEEF_0123_4567;
    step();
    mem_rvalid = 1'b0; mem_data = '0;
    checks++; if (req0_rvalid_mm !== 1'b1) begin errors++; $display("FAIL single_rvalid: got %b exp 1", req0_rvalid_mm); end
    checks++; if (req0_data_mm !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("FAIL single_data: got %h exp deadbeef01234567", req0_data_mm); end
    checks++; if ({req1_rvalid_mm, req1_data_mm} !== 65'h0) begin errors++; $display("FAIL single_req1_quiet: got %b %h exp 0", req1_rvalid_mm, req1_data_mm); end
    checks++; if (mem_arvalid !== 1'b0) begin errors++; $display("FAIL single_arvalid_drop: got %b exp 0", mem_arvalid); end
    step();
    checks++; if ({req0_rvalid_mm, grant} !== 3'b000) begin errors++; $display("FAIL single_one_cycle: got %b exp 000", {req0_rvalid_mm, grant}); end
    checks++; if (req0_data_mm !== 64'h0) begin errors++; $display("FAIL single_data_clear: got %h exp 0", req0_data_mm); end
    step();
    checks++; if ({grant, mem_arvalid} !== 3'b000) begin errors++; $display("FAIL single_masked: got %b exp 000", {grant, mem_arvalid}); end
    req0_arvalid = 1'b0;
    step();
  endtask

  task automatic test_tie();
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    req0_arvalid = 1'b1; req0_addr = 32'h0000_0100;
    req1_arvalid = 1'b1; req1_addr = 32'h0000_0200;
    step();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL tie_first_grant: got %b exp 01", grant); end
    checks++; if (mem_addr !== 32'h0000_0100) begin errors++; $display("FAIL tie_first_addr: got %h exp 00000100", mem_addr); end
    mem_rvalid = 1'b1; mem_data = 64'hA0A0_A0A0_0000_0001;
    step();
    mem_rvalid = 1'b0;
    checks++; if (req0_data_mm !== 64'hA0A0_A0A0_0000_0001 || req0_rvalid_mm !== 1'b1) begin errors++; $display("FAIL tie_first_resp: got %b %h exp 1 a0a0a0a000000001", req0_rvalid_mm, req0_data_mm); end
    step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_idle: got %b exp 00", grant); end
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL tie_second_grant: got %b exp 10", grant); end
    checks++; if (mem_addr !== 32'h0000_0200) begin errors++; $display("FAIL tie_second_addr: got %h exp 00000200", mem_addr); end
    req0_arvalid = 1'b0;
    mem_rvalid = 1'b1; mem_data = 64'hB0B0_B0B0_0000_0002;
    step();
    mem_rvalid = 1'b0; req1_arvalid = 1'b0;
    checks++; if ({req1_rvalid_mm, req1_data_mm} !== {1'b1, 64'hB0B0_B0B0_0000_0002}) begin errors++; $display("FAIL tie_second_resp: got %b %h exp 1 b0b0b0b000000002", req1_rvalid_mm, req1_data_mm); end
    checks++; if ({req0_rvalid_mm, req0_data_mm} !== 65'h0) begin errors++; $display("FAIL tie_req0_quiet: got %b %h exp 0", req0_rvalid_mm, req0_data_mm); end
    step(); step();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL tie_no_reissue: got %b exp 00", grant); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_g;
    for (int i = 0; i < 4; i++) begin
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      req0_arvalid = 1'b1; req1_arvalid = 1'b1;
      req0_addr = 32'h0000_3000 + 32'(i); req1_addr = 32'h0000_4000 + 32'(i);
      step();
      checks++; if (grant !== exp_g) begin errors++; $display("FAIL b2b_grant[%0d]: got %b exp %b", i, grant, exp_g); end
      mem_rvalid = 1'b1; mem_data = 64'hC0DE_0000_0000_0000 + 64'(i);
      step();
      mem_rvalid = 1'b0; req0_arvalid = 1'b0; req1_arvalid = 1'b0;
      checks++; if ({req1_rvalid_mm, req0_rvalid_mm} !== exp_g) begin errors++; $display("FAIL b2b_rvalid[%0d]: got %b exp %b", i, {req1_rvalid_mm, req0_rvalid_mm}, exp_g); end
      step();
    end
  endtask

  task automatic test_timeout();
    req0_arvalid = 1'b1; req0_addr = 32'h0000_0300;
    step();
    checks++; if ({grant, mem_arvalid} !== 3'b011) begin errors++; $display("FAIL to_grant: got %b exp 011", {grant, mem_arvalid}); end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if ({mem_arvalid, err_timeout} !== 2'b10) begin errors++; $display("FAIL to_wait[%0d]: got %b exp 10", i, {mem_arvalid, err_timeout}); end
    end
    step();
    checks++; if ({err_timeout, mem_arvalid, grant} !== 4'b1000) begin errors++; $display("FAIL to_abort: got %b exp 1000", {err_timeout, mem_arvalid, grant}); end
    checks++; if (req0_rvalid_mm !== 1'b0) begin errors++; $display("FAIL to_no_resp: got %b exp 0", req0_rvalid_mm); end
    step();
    checks++; if ({err_timeout, mem_arvalid, grant} !== 4'b0101) begin errors++; $display("FAIL to_rearb: got %b exp 0101", {err_timeout, mem_arvalid, grant}); end
    mem_rvalid = 1'b1; mem_data = 64'h0000_0000_0000_0333;
    step();
    mem_rvalid = 1'b0; req0_arvalid = 1'b0;
    checks++; if ({req0_rvalid_mm, req0_data_mm} !== {1'b1, 64'h333}) begin errors++; $display("FAIL to_rearb_resp: got %b %h exp 1 333", req0_rvalid_mm, req0_data_mm); end
    step(); step();
  endtask

  task automatic test_data_wins();
    req1_arvalid = 1'b1; req1_addr = 32'h0000_0700;
    step();
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL dw_grant: got %b exp 10", grant); end
    step(); step(); step(); step();
    mem_rvalid = 1'b1; mem_data = 64'h7777_0000_0000_7777;
    step();
    mem_rvalid = 1'b0; req1_arvalid = 1'b0;
    checks++; if ({req1_rvalid_mm, err_timeout} !== 2'b10) begin errors++; $display("FAIL dw_resp: got %b exp 10", {req1_rvalid_mm, err_timeout}); end
    checks++; if (req1_data_mm !== 64'h7777_0000_0000_7777) begin errors++; $display("FAIL dw_data: got %h exp 7777000000007777", req1_data_mm); end
    step();
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL dw_no_err: got %b exp 0", err_timeout); end
    step();
  endtask

  task automatic test_drop_during_wait();
    req1_arvalid = 1'b1; req1_addr = 32'h0000_0500;
    step();
    checks++; if ({grant, mem_addr} !== {2'b10, 32'h0000_0500}) begin errors++; $display("FAIL drop_grant: got %b %h exp 10 00000500", grant, mem_addr); end
    req1_arvalid = 1'b0; req0_arvalid = 1'b1; req0_addr = 32'h0000_0600;
    step();
    checks++; if ({grant, mem_addr} !== {2'b10, 32'h0000_0500}) begin errors++; $display("FAIL drop_addr_stable: got %b %h exp 10 00000500", grant, mem_addr); end
    mem_rvalid = 1'b1; mem_data = 64'h5555_5555_5555_5555;
    step();
    mem_rvalid = 1'b0;
    checks++; if ({req1_rvalid_mm, req1_data_mm} !== {1'b1, 64'h5555_5555_5555_5555}) begin errors++; $display("FAIL drop_resp: got %b %h exp 1 5555555555555555", req1_rvalid_mm, req1_data_mm); end
    step(); step();
    checks++; if ({grant, mem_addr} !== {2'b01, 32'h0000_0600}) begin errors++; $display("FAIL drop_next: got %b %h exp 01 00000600", grant, mem_addr); end
    mem_rvalid = 1'b1; mem_data = 64'h6;
    step();
    mem_rvalid = 1'b0; req0_arvalid = 1'b0;
    step(); step();
  endtask

  task automatic test_reset_mid_wait();
    req0_arvalid = 1'b1; req0_addr = 32'h0000_0400;
    step(); step();
    checks++; if (mem_arvalid !== 1'b1) begin errors++; $display("FAIL rmw_wait: got %b exp 1", mem_arvalid); end
    rst_n = 1'b0; req0_arvalid = 1'b0;
    step();
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_data = 64'h4444_4444_4444_4444;
    step();
    mem_rvalid = 1'b0;
    checks++; if ({req0_rvalid_mm, req1_rvalid_mm, mem_arvalid, err_timeout, grant} !== 6'b0) begin errors++; $display("FAIL rmw_outputs: got %b exp 000000", {req0_rvalid_mm, req1_rvalid_mm, mem_arvalid, err_timeout, grant}); end
    checks++; if ({mem_addr, req0_data_mm, req1_data_mm} !== 160'h0) begin errors++; $display("FAIL rmw_buses: got %h %h %h exp 0", mem_addr, req0_data_mm, req1_data_mm); end
    step();
    checks++; if ({req0_rvalid_mm, req1_rvalid_mm} !== 2'b00) begin errors++; $display("FAIL rmw_late: got %b exp 00", {req0_rvalid_mm, req1_rvalid_mm}); end
  endtask

  task automatic test_spurious();
    mem_rvalid = 1'b1; mem_data = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); step();
    mem_rvalid = 1'b0;
    checks++; if ({req0_rvalid_mm, req1_rvalid_mm, mem_arvalid, err_timeout, grant} !== 6'b0) begin errors++; $display("FAIL spur_outputs: got %b exp 000000", {req0_rvalid_mm, req1_rvalid_mm, mem_arvalid, err_timeout, grant}); end
    checks++; if ({mem_addr, req0_data_mm, req1_data_mm} !== 160'h0) begin errors++; $display("FAIL spur_buses: got %h %h %h exp 0", mem_addr, req0_data_mm, req1_data_mm); end
  endtask

  initial begin
    rst_n = 1'b0; req0_arvalid = 1'b0; req1_arvalid = 1'b0;
    req0_addr = '0; req1_addr = '0; mem_rvalid = 1'b0; mem_data = '0;
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_timeout();
    test_data_wins();
    test_drop_during_wait();
    test_reset_mid_wait();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width.
REQ-002 Parameter DATA_W, default 64, memory line width.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before abort (1..255).
REQ-004 clk  in  1  clock; all state updates on the falling edge, matching the cache clients.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 req0_arvalid  in  1  requester 0 miss request (level).
REQ-007 req0_addr  in  ADDR_W  requester 0 miss address.
REQ-008 req0_rvalid_mm  out  1  line-fill strobe to requester 0.
REQ-009 req0_data_mm  out  DATA_W  line-fill data to requester 0.
REQ-010 req1_arvalid, req1_addr, req1_rvalid_mm, req1_data_mm: identical to REQ-006..009 for requester 1.
REQ-011 mem_arvalid  out  1  read request to main memory.
REQ-012 mem_addr  out  ADDR_W  latched address of the granted request.
REQ-013 mem_rvalid  in  1  memory read-data valid.
REQ-014 mem_data  in  DATA_W  memory read data.
REQ-015 grant  out  2  one-hot owner of the memory port; 00 when idle.
REQ-016 err_timeout  out  1  one-cycle pulse on aborted transaction.

Function
REQ-017 FSM states SHALL be IDLE, WAIT, RESP; one transaction outstanding at a time.
REQ-018 IDLE: eligible requester = arvalid high and not masked (REQ-024); none eligible -> stay IDLE.
REQ-019 IDLE, one eligible: grant it; both eligible: grant the one not equal to last_grant (round-robin).
REQ-020 On grant: latch address into mem_addr, set grant, assert mem_arvalid, clear timeout counter, go WAIT; mem_arvalid high from the next edge.
REQ-021 WAIT: mem_arvalid held 1, mem_addr stable; counter increments each cycle.
REQ-022 WAIT with mem_rvalid=1: capture mem_data, drop mem_arvalid, go RESP.
REQ-023 RESP: granted reqN_rvalid_mm=1 for exactly one cycle with captured data; other requester's rvalid_mm=0 and data_mm=0; set last_grant=owner, set owner's mask bit, grant=00, go IDLE.
REQ-024 Mask bit N SHALL clear on any cycle reqN_arvalid=0; masked requester is not eligible (prevents reissue while the cache absorbs the fill and still holds arvalid).
REQ-025 WAIT with counter==TIMEOUT and mem_rvalid=0: drop mem_arvalid, pulse err_timeout, grant=00, no response, no mask set, last_grant unchanged, go IDLE.
REQ-026 mem_rvalid=1 and counter==TIMEOUT same cycle: data wins, no timeout.
REQ-027 mem_rvalid in IDLE or RESP SHALL be ignored.
REQ-028 Granted reqN_arvalid dropping during WAIT: transaction completes and response is still delivered.
REQ-029 Request addresses of non-granted requester SHALL not affect mem_addr.
REQ-030 Minimum latency: arvalid high at edge k -> mem_arvalid at k+1 -> (mem_rvalid at edge m) -> reqN_rvalid_mm at m+1.

Reset
REQ-031 rst_n=0 at a falling edge: state IDLE, mem_arvalid=0, mem_addr=0, grant=00, reqN_rvalid_mm=0, reqN_data_mm=0, err_timeout=0, counter=0, masks=00, last_grant=1 (requester 0 wins first tie).
REQ-032 Reset during WAIT or RESP SHALL abandon the transaction; no response delivered afterward.

Verification
REQ-033 Single request: req0 addr 0x0000_1040, mem_rvalid 3 cycles later with data 0xDEAD_BEEF_0123_4567 -> mem_addr 0x0000_1040, req0_rvalid_mm one cycle with that data, req1 outputs 0.
REQ-034 Tie after reset: req0 and req1 both high -> grant 01 first; after completion (req0 held high 2 more cycles) -> grant 10 next, req0 not reissued.
REQ-035 Back-to-back ties with fresh requests each time -> grants alternate 01,10,01,10.
REQ-036 Timeout: TIMEOUT=4, no mem_rvalid -> err_timeout pulse after 4 WAIT cycles, mem_arvalid 0, request re-arbitrated next IDLE cycle.
REQ-037 Reset asserted mid-WAIT then late mem_rvalid -> no reqN_rvalid_mm pulse, all outputs at REQ-031 values.
REQ-038 Spurious mem_rvalid in IDLE -> no output change.
